// File: rtl/paralelo_serial_tx_pkg.sv
// Shared definitions for the serializer and its receive-side counterpart.
package paralelo_serial_tx_pkg;

    localparam int SYM_WIDTH = 8;

    // K28.5 comma, also matched by the deserializer's comma detector.
    localparam logic [7:0] K28_5 = 8'hBC;

    typedef enum logic {
        SYNC = 1'b0,
        RUN  = 1'b1
    } tx_state_e;

endpackage

// File: rtl/paralelo_serial_tx_contador_simbolo.sv
// Bit position counter within a symbol; flags the enabled edge that starts a new symbol.
import paralelo_serial_tx_pkg::*;

module contador_simbolo #(
    parameter int WIDTH = SYM_WIDTH,
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enb,
    output logic [CNT_W-1:0] bit_cnt,
    output logic             boundary
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0] bit_cnt_q;
    logic [CNT_W-1:0] bit_cnt_d;
    logic             last;

    always_comb begin
        last      = (bit_cnt_q == LAST);
        bit_cnt_d = last ? '0 : bit_cnt_q + CNT_W'(1);
    end

    // Reset parks on the last position so the first enabled edge is a boundary.
    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt_q <= LAST;
        end else if (enb) begin
            bit_cnt_q <= bit_cnt_d;
        end
    end

    assign bit_cnt  = bit_cnt_q;
    assign boundary = enb & last;

endmodule

// File: rtl/paralelo_serial_tx.sv
// Parallel-to-serial transmitter: valid/ready symbol intake, idle fill, post-reset alignment run.
//   state | meaning
//   SYNC  | forced idle symbols after reset, no data accepted
//   RUN   | data sent when offered at a boundary, idle otherwise
import paralelo_serial_tx_pkg::*;

module paralelo_serial_tx #(
    parameter int               WIDTH     = SYM_WIDTH,
    parameter logic [WIDTH-1:0] IDLE_SYM  = WIDTH'(K28_5),
    parameter int               SYNC_SYMS = 4,
    parameter bit               MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enb,
    input  logic [WIDTH-1:0] entrada,
    input  logic             valid_in,
    output logic             ready_out,
    output logic             salida,
    output logic             sym_start,
    output logic             active,
    output logic             synced
);

    localparam logic [7:0] SYNC_LAST = 8'(SYNC_SYMS - 1);

    tx_state_e        state_q, state_d;
    logic [7:0]       sync_cnt_q, sync_cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             salida_q, salida_d;
    logic             sym_start_q, sym_start_d;
    logic             active_q, active_d;
    logic             synced_q, synced_d;

    logic             boundary;
    logic             accept;
    logic [WIDTH-1:0] next_sym;

    contador_simbolo #(
        .WIDTH(WIDTH)
    ) u_contador (
        .clk     (clk),
        .reset   (reset),
        .enb     (enb),
        .bit_cnt (),
        .boundary(boundary)
    );

    assign ready_out = boundary & (state_q == RUN);
    assign accept    = valid_in & ready_out;

    always_comb begin
        state_d     = state_q;
        sync_cnt_d  = sync_cnt_q;
        shreg_d     = shreg_q;
        salida_d    = salida_q;
        sym_start_d = sym_start_q;
        active_d    = active_q;
        synced_d    = synced_q;
        next_sym    = accept ? entrada : IDLE_SYM;

        if (boundary) begin
            if (MSB_FIRST) begin
                salida_d = next_sym[WIDTH-1];
                shreg_d  = {next_sym[WIDTH-2:0], 1'b0};
            end else begin
                salida_d = next_sym[0];
                shreg_d  = {1'b0, next_sym[WIDTH-1:1]};
            end
            sym_start_d = 1'b1;
            active_d    = accept;
            if (state_q == SYNC) begin
                sync_cnt_d = sync_cnt_q + 8'd1;
                if (sync_cnt_q == SYNC_LAST) begin
                    state_d  = RUN;
                    synced_d = 1'b1;
                end
            end
        end else if (enb) begin
            if (MSB_FIRST) begin
                salida_d = shreg_q[WIDTH-1];
                shreg_d  = {shreg_q[WIDTH-2:0], 1'b0};
            end else begin
                salida_d = shreg_q[0];
                shreg_d  = {1'b0, shreg_q[WIDTH-1:1]};
            end
            sym_start_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= SYNC;
            sync_cnt_q  <= '0;
            shreg_q     <= '0;
            salida_q    <= 1'b0;
            sym_start_q <= 1'b0;
            active_q    <= 1'b0;
            synced_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_cnt_q  <= sync_cnt_d;
            shreg_q     <= shreg_d;
            salida_q    <= salida_d;
            sym_start_q <= sym_start_d;
            active_q    <= active_d;
            synced_q    <= synced_d;
        end
    end

    assign salida    = salida_q;
    assign sym_start = sym_start_q;
    assign active    = active_q;
    assign synced    = synced_q;

endmodule

// File: tb/tb_paralelo_serial_tx.sv
// Directed bench for paralelo_serial_tx: default instance plus an LSB-first, one-symbol-sync instance.
module tb_paralelo_serial_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, enb, valid_in;
    logic [7:0] entrada;
    logic       ready_out, salida, sym_start, active, synced;

    logic       reset2, valid2;
    logic [7:0] entrada2;
    logic       ready2, salida2, sym_start2, active2, synced2;

    int   checks = 0;
    int   errors = 0;
    logic rdy_s, rdy2_s;
    logic [7:0] idle_v = 8'hBC;

    typedef struct {
        logic       valid;
        logic [7:0] data;
        logic [7:0] exp_bits;
        logic       exp_active;
    } sym_vec_t;

    sym_vec_t vecs[6];

    paralelo_serial_tx dut (
        .clk      (clk),
        .reset    (reset),
        .enb      (enb),
        .entrada  (entrada),
        .valid_in (valid_in),
        .ready_out(ready_out),
        .salida   (salida),
        .sym_start(sym_start),
        .active   (active),
        .synced   (synced)
    );

    paralelo_serial_tx #(
        .SYNC_SYMS(1),
        .MSB_FIRST(1'b0)
    ) dut_lsb (
        .clk      (clk),
        .reset    (reset2),
        .enb      (enb),
        .entrada  (entrada2),
        .valid_in (valid2),
        .ready_out(ready2),
        .salida   (salida2),
        .sym_start(sym_start2),
        .active   (active2),
        .synced   (synced2)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ready_out is combinational: capture it before the edge, registered outputs just after.
    task automatic tick();
        @(negedge clk);
        rdy_s  = ready_out;
        rdy2_s = ready2;
        @(posedge clk);
        #1;
    endtask

    task automatic sync_phase(input logic v, input logic [7:0] d);
        valid_in = v;
        entrada  = d;
        for (int k = 0; k < 32; k++) begin
            tick();
            chk("sync_ready", {7'd0, rdy_s}, 8'd0);
            chk("sync_salida", {7'd0, salida}, {7'd0, idle_v[7 - (k % 8)]});
            chk("sync_sym_start", {7'd0, sym_start}, {7'd0, (k % 8) == 0});
            chk("sync_active", {7'd0, active}, 8'd0);
            chk("sync_synced", {7'd0, synced}, {7'd0, k >= 24});
        end
    endtask

    task automatic send_sym(input sym_vec_t v, output int accepts);
        accepts  = 0;
        valid_in = v.valid;
        entrada  = v.data;
        for (int j = 0; j < 8; j++) begin
            tick();
            chk("sym_ready", {7'd0, rdy_s}, {7'd0, j == 0});
            if (rdy_s && valid_in) accepts++;
            chk("sym_salida", {7'd0, salida}, {7'd0, v.exp_bits[7 - j]});
            chk("sym_start", {7'd0, sym_start}, {7'd0, j == 0});
            chk("sym_active", {7'd0, active}, {7'd0, v.exp_active});
            chk("sym_synced", {7'd0, synced}, 8'd1);
        end
    endtask

    initial begin
        int acc, acc_total, acc_b2b;
        logic [7:0] bits;
        sym_vec_t v3c;

        vecs[0] = '{1'b1, 8'h66, 8'h66, 1'b1};
        vecs[1] = '{1'b0, 8'h00, 8'hBC, 1'b0};
        vecs[2] = '{1'b1, 8'hA5, 8'hA5, 1'b1};
        vecs[3] = '{1'b1, 8'h00, 8'h00, 1'b1};
        vecs[4] = '{1'b1, 8'hFF, 8'hFF, 1'b1};
        vecs[5] = '{1'b0, 8'h00, 8'hBC, 1'b0};

        reset = 1'b1; enb = 1'b1; valid_in = 1'b0; entrada = 8'h00;
        reset2 = 1'b1; valid2 = 1'b0; entrada2 = 8'h00;

        // Reset held three cycles.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_salida", {7'd0, salida}, 8'd0);
            chk("rst_synced", {7'd0, synced}, 8'd0);
            chk("rst_sym_start", {7'd0, sym_start}, 8'd0);
            chk("rst_active", {7'd0, active}, 8'd0);
            if (i > 0) chk("rst_ready", {7'd0, rdy_s}, 8'd0);
        end
        reset = 1'b0;
        sync_phase(1'b0, 8'h00);

        // Table: single data symbol, idle, back-to-back trio, idle.
        acc_total = 0;
        acc_b2b   = 0;
        for (int i = 0; i < 6; i++) begin
            send_sym(vecs[i], acc);
            acc_total += acc;
            if (i >= 2 && i <= 4) acc_b2b += acc;
        end
        chk("b2b_accepts", 8'(acc_b2b), 8'd3);
        chk("total_accepts", 8'(acc_total), 8'd4);

        // Stall with enb low after four bits of 8'h66.
        bits = 8'h66;
        valid_in = 1'b1;
        entrada  = bits;
        for (int j = 0; j < 4; j++) begin
            tick();
            if (j == 0) begin
                chk("stall_accept", {7'd0, rdy_s}, 8'd1);
                valid_in = 1'b0;
            end
            chk("stall_pre_salida", {7'd0, salida}, {7'd0, bits[7 - j]});
            chk("stall_pre_active", {7'd0, active}, 8'd1);
        end
        enb = 1'b0;
        for (int j = 0; j < 5; j++) begin
            tick();
            chk("stall_ready", {7'd0, rdy_s}, 8'd0);
            chk("stall_salida", {7'd0, salida}, {7'd0, bits[4]});
            chk("stall_sym_start", {7'd0, sym_start}, 8'd0);
            chk("stall_active", {7'd0, active}, 8'd1);
        end
        enb = 1'b1;
        for (int j = 4; j < 8; j++) begin
            tick();
            chk("resume_ready", {7'd0, rdy_s}, 8'd0);
            chk("resume_salida", {7'd0, salida}, {7'd0, bits[7 - j]});
            chk("resume_active", {7'd0, active}, 8'd1);
            chk("resume_sym_start", {7'd0, sym_start}, 8'd0);
        end
        tick();
        chk("stall_len_boundary", {7'd0, rdy_s}, 8'd1);
        chk("post_stall_salida", {7'd0, salida}, {7'd0, idle_v[7]});
        chk("post_stall_sym_start", {7'd0, sym_start}, 8'd1);
        chk("post_stall_active", {7'd0, active}, 8'd0);
        for (int j = 1; j < 8; j++) begin
            tick();
            chk("post_stall_idle", {7'd0, salida}, {7'd0, idle_v[7 - j]});
        end

        // Reset after four bits of a data symbol; valid held high through reset.
        bits = 8'hA5;
        valid_in = 1'b1;
        entrada  = bits;
        for (int j = 0; j < 4; j++) begin
            tick();
            if (j == 0) valid_in = 1'b0;
            chk("mid_salida", {7'd0, salida}, {7'd0, bits[7 - j]});
            chk("mid_active", {7'd0, active}, 8'd1);
        end
        reset = 1'b1;
        valid_in = 1'b1;
        entrada  = 8'h3C;
        tick();
        chk("midrst_salida", {7'd0, salida}, 8'd0);
        chk("midrst_synced", {7'd0, synced}, 8'd0);
        chk("midrst_active", {7'd0, active}, 8'd0);
        chk("midrst_sym_start", {7'd0, sym_start}, 8'd0);
        reset = 1'b0;
        sync_phase(1'b1, 8'h3C);
        v3c = '{1'b1, 8'h3C, 8'h3C, 1'b1};
        send_sym(v3c, acc);
        chk("resync_accepts", 8'(acc), 8'd1);
        valid_in = 1'b0;

        // LSB-first instance, one sync symbol, then 8'h01.
        chk("lsb_rst_salida", {7'd0, salida2}, 8'd0);
        chk("lsb_rst_synced", {7'd0, synced2}, 8'd0);
        valid2   = 1'b1;
        entrada2 = 8'h01;
        reset2   = 1'b0;
        for (int j = 0; j < 8; j++) begin
            tick();
            chk("lsb_sync_ready", {7'd0, rdy2_s}, 8'd0);
            chk("lsb_idle_salida", {7'd0, salida2}, {7'd0, idle_v[j]});
            chk("lsb_idle_sym_start", {7'd0, sym_start2}, {7'd0, j == 0});
            chk("lsb_idle_active", {7'd0, active2}, 8'd0);
            chk("lsb_synced", {7'd0, synced2}, 8'd1);
        end
        bits = 8'h01;
        for (int j = 0; j < 8; j++) begin
            tick();
            chk("lsb_data_ready", {7'd0, rdy2_s}, {7'd0, j == 0});
            if (j == 0) valid2 = 1'b0;
            chk("lsb_data_salida", {7'd0, salida2}, {7'd0, bits[j]});
            chk("lsb_data_active", {7'd0, active2}, 8'd1);
        end
        tick();
        chk("lsb_idle_again_active", {7'd0, active2}, 8'd0);
        chk("lsb_idle_again_salida", {7'd0, salida2}, {7'd0, idle_v[0]});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
